// File: rtl/pwm_feed_pkg.sv
// Shared types and constants for the PWM feed sequencer.
// Optional mute-on-underrun behaviour is selected by PWM_FEED_MUTE_ON_UNDERRUN_EN.
package pwm_feed_pkg;

    localparam int         DATA_W_DEFAULT = 24;
    localparam logic [7:0] UNDERRUN_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Saturating increment for the 8-bit underrun counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == UNDERRUN_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/pwm_feed_ctrl_if.sv
// Sample-write and PWM-core signal bundle for pwm_feed_ctrl.
// The slave modport is the sequencer side; the master modport is the producer/observer side.
interface pwm_feed_ctrl_if #(
    parameter int DATA_W = pwm_feed_pkg::DATA_W_DEFAULT,
    parameter int DEPTH  = 8
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic [LVL_W-1:0]  level;
    logic [DATA_W-1:0] pwm_data;
    logic              pwm_cs;
    logic              pwm_start;

    modport master (
        output wr_en,
        output wr_data,
        input  full,
        input  level,
        input  pwm_data,
        input  pwm_cs,
        input  pwm_start
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output full,
        output level,
        output pwm_data,
        output pwm_cs,
        output pwm_start
    );

endinterface

// File: rtl/pwm_feed_fifo.sv
// Synchronous sample FIFO; DEPTH must be a power of two so the pointers wrap for free.
// Push is refused when full, pop is refused when empty; both see the pre-edge level.
module pwm_feed_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push;
    logic              do_pop;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: a flushed FIFO never exposes stale entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pwm_feed_ctrl.sv
// Paces buffered audio samples into the PWM DAC core at a programmable rate.
// Define PWM_FEED_MUTE_ON_UNDERRUN_EN to output zero on an underrun tick instead of holding.
module pwm_feed_ctrl
    import pwm_feed_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int DEPTH     = 8,
    parameter int DIV_W     = 16,
    parameter int PRIME_LVL = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div,
    pwm_feed_ctrl_if.slave    bus,
    output logic [7:0]        underrun_cnt,
    output logic              busy
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] pwm_data_q, pwm_data_d;
    logic [7:0]        underrun_q, underrun_d;

    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic              pwm_cs;
    logic              pwm_start;

    pwm_feed_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign bus.full      = fifo_full;
    assign bus.level     = fifo_level;
    assign bus.pwm_data  = pwm_data_q;
    assign bus.pwm_cs    = pwm_cs;
    assign bus.pwm_start = pwm_start;
    assign underrun_cnt  = underrun_q;
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pwm_data_d = pwm_data_q;
        underrun_d = underrun_q;
        fifo_pop   = 1'b0;
        pwm_cs     = 1'b0;
        pwm_start  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = PRIME;
                    div_d   = div;
                end
            end

            PRIME: begin
                pwm_cs = 1'b1;
                if (!enable) begin
                    state_d = IDLE;
                end else if (fifo_level >= LVL_W'(PRIME_LVL)) begin
                    state_d    = RUN;
                    fifo_pop   = 1'b1;
                    pwm_data_d = fifo_data;
                    cnt_d      = div_q;
                end
            end

            RUN: begin
                pwm_cs    = 1'b1;
                pwm_start = 1'b1;
                // Dropping enable wins over a coincident tick; the FIFO is left untouched.
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d = div_q;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        pwm_data_d = fifo_data;
                    end else begin
                        underrun_d = sat_inc8(underrun_q);
`ifdef PWM_FEED_MUTE_ON_UNDERRUN_EN
                        pwm_data_d = '0;
`else
                        pwm_data_d = pwm_data_q;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            pwm_data_q <= '0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pwm_data_q <= pwm_data_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_pwm_feed_ctrl.sv
// Self-checking bench for pwm_feed_ctrl: vector table, directed corner sequences and
// randomized traffic, all compared against a queue-based reference model.
module tb_pwm_feed_ctrl;
    import pwm_feed_pkg::*;

    localparam int DATA_W    = 24;
    localparam int DEPTH     = 8;
    localparam int DIV_W     = 16;
    localparam int PRIME_LVL = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [DIV_W-1:0]  div;
    logic [7:0]        underrun_cnt;
    logic              busy;

    pwm_feed_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    pwm_feed_ctrl #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .DIV_W     (DIV_W),
        .PRIME_LVL (PRIME_LVL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .div          (div),
        .bus          (bus),
        .underrun_cnt (underrun_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int last_chg = 0;

    // Reference model: mode 0 idle, 1 priming, 2 playing; ticks come from the age of playback.
    logic [DATA_W-1:0] m_q[$];
    int                m_mode  = 0;
    int                m_div   = 0;
    int                m_age   = 0;
    int                m_under = 0;
    logic [DATA_W-1:0] m_data  = '0;

    typedef struct {
        logic              rst;
        logic              en;
        logic              wr;
        logic [DATA_W-1:0] wd;
        logic [DIV_W-1:0]  dv;
        int                lvl;
        logic              cs;
        logic              st;
        logic [DATA_W-1:0] pd;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic rst, logic en, logic wr, logic [DATA_W-1:0] wd,
                                logic [DIV_W-1:0] dv, int lvl, logic cs, logic st,
                                logic [DATA_W-1:0] pd);
        vec_t v;
        v.rst = rst; v.en = en; v.wr = wr; v.wd = wd; v.dv = dv;
        v.lvl = lvl; v.cs = cs; v.st = st; v.pd = pd;
        return v;
    endfunction

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int pre_len;
        logic pre_full;
        if (reset) begin
            m_q.delete();
            m_mode  = 0;
            m_div   = 0;
            m_age   = 0;
            m_under = 0;
            m_data  = '0;
        end else begin
            pre_len  = m_q.size();
            pre_full = (pre_len == DEPTH);
            case (m_mode)
                0: if (enable) begin
                    m_mode = 1;
                    m_div  = int'(div);
                end
                1: if (!enable) m_mode = 0;
                   else if (pre_len >= PRIME_LVL) begin
                       m_data = m_q.pop_front();
                       m_mode = 2;
                       m_age  = 0;
                   end
                default: if (!enable) m_mode = 0;
                   else begin
                       if (m_age % (m_div + 1) == m_div) begin
                           if (pre_len > 0) m_data = m_q.pop_front();
                           else begin
                               if (m_under < 255) m_under++;
`ifdef PWM_FEED_MUTE_ON_UNDERRUN_EN
                               m_data = '0;
`endif
                           end
                       end
                       m_age++;
                   end
            endcase
            if (bus.wr_en && !pre_full) m_q.push_back(bus.wr_data);
        end
    endtask

    task automatic check_model();
        check_output("level",     32'(bus.level),     32'(m_q.size()));
        check_output("full",      32'(bus.full),      32'(m_q.size() == DEPTH));
        check_output("pwm_data",  32'(bus.pwm_data),  32'(m_data));
        check_output("pwm_cs",    32'(bus.pwm_cs),    32'(m_mode != 0));
        check_output("pwm_start", 32'(bus.pwm_start), 32'(m_mode == 2));
        check_output("busy",      32'(busy),          32'(m_mode != 0));
        check_output("underrun",  32'(underrun_cnt),  32'(m_under));
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check_model();
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset       = v.rst;
        enable      = v.en;
        bus.wr_en   = v.wr;
        bus.wr_data = v.wd;
        div         = v.dv;
        step_cycle();
    endtask

    task automatic wait_change(output logic [DATA_W-1:0] val, output int gap);
        logic [DATA_W-1:0] prev;
        logic changed;
        prev    = bus.pwm_data;
        changed = 1'b0;
        for (int i = 0; i < 30 && !changed; i++) begin
            step_cycle();
            changed = (bus.pwm_data !== prev);
        end
        check_output("change_seen", 32'(changed), 32'd1);
        val      = bus.pwm_data;
        gap      = cyc - last_chg;
        last_chg = cyc;
    endtask

    logic [DATA_W-1:0] exp_seq[7];
    logic [DATA_W-1:0] got;
    int                gap;

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        div         = '0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;

        tbl[0]  = mk(1, 0, 0, 24'h0,      16'd0, 0, 0, 0, 24'h0);
        tbl[1]  = mk(0, 0, 1, 24'h000011, 16'd0, 1, 0, 0, 24'h0);
        tbl[2]  = mk(0, 0, 1, 24'h000022, 16'd0, 2, 0, 0, 24'h0);
        tbl[3]  = mk(0, 0, 1, 24'h000033, 16'd0, 3, 0, 0, 24'h0);
        tbl[4]  = mk(1, 0, 0, 24'h0,      16'd0, 0, 0, 0, 24'h0);
        tbl[5]  = mk(0, 0, 1, 24'h0000A1, 16'd0, 1, 0, 0, 24'h0);
        tbl[6]  = mk(0, 0, 1, 24'h0000A2, 16'd0, 2, 0, 0, 24'h0);
        tbl[7]  = mk(0, 1, 0, 24'h0,      16'd9, 2, 1, 0, 24'h0);
        tbl[8]  = mk(0, 1, 1, 24'h000100, 16'd0, 3, 1, 0, 24'h0);
        tbl[9]  = mk(0, 1, 1, 24'h000200, 16'd0, 4, 1, 0, 24'h0);
        tbl[10] = mk(0, 1, 0, 24'h0,      16'd0, 3, 1, 1, 24'h0000A1);
        for (int i = 11; i < 20; i++)
            tbl[i] = mk(0, 1, 0, 24'h0, 16'd0, 3, 1, 1, 24'h0000A1);
        tbl[20] = mk(0, 1, 0, 24'h0,      16'd0, 2, 1, 1, 24'h0000A2);

        // Reset, idle buffering, priming and the first paced tick.
        for (int i = 0; i < 21; i++) begin
            apply_stimulus(tbl[i]);
            check_output($sformatf("tbl%0d_level", i), 32'(bus.level),     32'(tbl[i].lvl));
            check_output($sformatf("tbl%0d_cs", i),    32'(bus.pwm_cs),    32'(tbl[i].cs));
            check_output($sformatf("tbl%0d_start", i), 32'(bus.pwm_start), 32'(tbl[i].st));
            check_output($sformatf("tbl%0d_busy", i),  32'(busy),          32'(tbl[i].cs));
            check_output($sformatf("tbl%0d_data", i),  32'(bus.pwm_data),  32'(tbl[i].pd));
        end
        last_chg = cyc;

        // Fill to DEPTH while playing, then push on the tick cycle of a full FIFO.
        for (int i = 1; i <= 6; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 24'h000300 + 24'(i);
            step_cycle();
        end
        bus.wr_en = 1'b0;
        while (cyc < last_chg + 9) step_cycle();
        check_output("full_before_tick", 32'(bus.full), 32'd1);
        bus.wr_en   = 1'b1;
        bus.wr_data = 24'hBADBAD;
        step_cycle();
        bus.wr_en = 1'b0;
        check_output("tick_full_level", 32'(bus.level),    32'd7);
        check_output("tick_full_data",  32'(bus.pwm_data), 32'h000100);
        last_chg = cyc;

        // Remaining samples leave in FIFO order, exactly ten cycles apart.
        exp_seq = '{24'h000200, 24'h000301, 24'h000302, 24'h000303,
                    24'h000304, 24'h000305, 24'h000306};
        for (int k = 0; k < 7; k++) begin
            wait_change(got, gap);
            check_output($sformatf("pace%0d_data", k),  32'(got),       32'(exp_seq[k]));
            check_output($sformatf("pace%0d_gap", k),   32'(gap),       32'd10);
            check_output($sformatf("pace%0d_level", k), 32'(bus.level), 32'(6 - k));
        end

        // Empty FIFO: three missed ticks, then saturation.
        repeat (30) step_cycle();
        check_output("underrun_3", 32'(underrun_cnt), 32'd3);
`ifdef PWM_FEED_MUTE_ON_UNDERRUN_EN
        check_output("underrun_data", 32'(bus.pwm_data), 32'h0);
`else
        check_output("underrun_data", 32'(bus.pwm_data), 32'h000306);
`endif
        repeat (3000) step_cycle();
        check_output("underrun_sat", 32'(underrun_cnt), 32'd255);

        // Re-prime with five samples and reset in the middle of playback.
        enable = 1'b0;
        step_cycle();
        check_output("idle_cs", 32'(bus.pwm_cs), 32'd0);
        for (int i = 0; i < 5; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 24'h000500 + 24'(i);
            step_cycle();
        end
        bus.wr_en = 1'b0;
        enable    = 1'b1;
        div       = 16'd9;
        step_cycle();
        step_cycle();
        check_output("rerun_data", 32'(bus.pwm_data), 32'h000500);
        bus.wr_en   = 1'b1;
        bus.wr_data = 24'h000505;
        step_cycle();
        bus.wr_en = 1'b0;
        check_output("pre_reset_level", 32'(bus.level), 32'd5);
        reset = 1'b1;
        step_cycle();
        reset = 1'b0;
        check_output("rst_level",    32'(bus.level),     32'd0);
        check_output("rst_cs",       32'(bus.pwm_cs),    32'd0);
        check_output("rst_start",    32'(bus.pwm_start), 32'd0);
        check_output("rst_data",     32'(bus.pwm_data),  32'd0);
        check_output("rst_underrun", 32'(underrun_cnt),  32'd0);
        check_output("rst_busy",     32'(busy),          32'd0);

        // Randomized traffic including short dividers, enable drops and resets.
        for (int i = 0; i < 2000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            enable      = ($urandom_range(0, 19) != 0);
            div         = DIV_W'($urandom_range(0, 3));
            bus.wr_en   = ($urandom_range(0, 4) < 2);
            bus.wr_data = DATA_W'($urandom);
            step_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
